// File: rtl/rom_arb_pkg.sv
// Shared types for the ROM read arbiter: FSM states, requester count and index type.
package rom_arb_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  typedef logic [$clog2(NUM_REQ)-1:0] req_idx_t;

  function automatic logic [NUM_REQ-1:0] idx2oh(input req_idx_t idx);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rom_rd_arbiter_if.sv
// Requester-side bundle of the ROM read arbiter: burst requests in, routed read data out.
interface rom_rd_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
);
  import rom_arb_pkg::*;

  logic [NUM_REQ-1:0]    req;
  logic [ADDR_WIDTH-1:0] start_addr0;
  logic [ADDR_WIDTH-1:0] start_addr1;
  logic [ADDR_WIDTH:0]   len0;
  logic [ADDR_WIDTH:0]   len1;
  logic [NUM_REQ-1:0]    ack;
  logic [NUM_REQ-1:0]    rvalid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [NUM_REQ-1:0]    done;

  modport master (
    output req, start_addr0, start_addr1, len0, len1,
    input  ack, rvalid, rdata, done
  );

  modport slave (
    input  req, start_addr0, start_addr1, len0, len1,
    output ack, rvalid, rdata, done
  );

endinterface

// File: rtl/rom_rr_arb.sv
// 2-way grant selection; round-robin by default, fixed priority (requester 0) when
// ROM_RD_ARB_FIXED_PRIO_EN is defined. Purely combinational.
module rom_rr_arb
  import rom_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
`ifndef ROM_RD_ARB_FIXED_PRIO_EN
  input  req_idx_t           last_winner,
`endif
  output logic [NUM_REQ-1:0] gnt,
  output req_idx_t           gnt_idx
);

  always_comb begin
    gnt_idx = '0;
    if (&req) begin
`ifdef ROM_RD_ARB_FIXED_PRIO_EN
      gnt_idx = '0;
`else
      gnt_idx = ~last_winner;
`endif
    end else if (req[1]) begin
      gnt_idx = 1'b1;
    end
    gnt = (|req) ? idx2oh(gnt_idx) : '0;
  end

endmodule

// File: rtl/rom_rd_arbiter.sv
// Shares one sync ROM read port between two burst requesters; ack same cycle as the IDLE grant,
// first word 2 cycles after ack, no back-pressure. ROM_RD_ARB_FIXED_PRIO_EN selects fixed priority.
module rom_rd_arbiter
  import rom_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ROM_DEPTH  = 256,
  parameter int ADDR_WIDTH = $clog2(ROM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  rom_rd_arbiter_if.slave       bus,
  output logic                  busy,
  output logic                  rom_en,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_dout
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ROM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   LEN_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_LEN = (ADDR_WIDTH+1)'(ROM_DEPTH);

  state_t                state_q, state_d;
  req_idx_t              owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
  logic                  run_q, run_d;
  logic                  rd_vld_q, rd_vld_d;
  logic                  rd_last_q, rd_last_d;
  req_idx_t              rd_owner_q, rd_owner_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [ADDR_WIDTH:0]   sel_len;
  logic [NUM_REQ-1:0]    gnt;
  req_idx_t              gnt_idx;

`ifndef ROM_RD_ARB_FIXED_PRIO_EN
  req_idx_t              last_winner_q, last_winner_d;
`endif

  rom_rr_arb u_arb (
    .req         (bus.req),
`ifndef ROM_RD_ARB_FIXED_PRIO_EN
    .last_winner (last_winner_q),
`endif
    .gnt         (gnt),
    .gnt_idx     (gnt_idx)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    bus.ack     = '0;
    rom_en      = 1'b0;
    rd_last_d   = 1'b0;
    sel_len     = '0;
`ifndef ROM_RD_ARB_FIXED_PRIO_EN
    last_winner_d = last_winner_q;
`endif
    unique case (state_q)
      IDLE: begin
        // run_q keeps ack quiet while reset is held and in the release cycle
        if (run_q && (|bus.req)) begin
          bus.ack     = gnt;
          owner_d     = gnt_idx;
          cur_addr_d  = gnt_idx[0] ? bus.start_addr1 : bus.start_addr0;
          sel_len     = gnt_idx[0] ? bus.len1 : bus.len0;
          remaining_d = (sel_len == '0) ? DEPTH_LEN : sel_len;
          state_d     = BURST;
`ifndef ROM_RD_ARB_FIXED_PRIO_EN
          last_winner_d = gnt_idx;
`endif
        end
      end
      BURST: begin
        rom_en      = 1'b1;
        cur_addr_d  = (cur_addr_q == LAST_ADDR) ? '0 : cur_addr_q + ADDR_ONE;
        remaining_d = remaining_q - LEN_ONE;
        if (remaining_q == LEN_ONE) begin
          rd_last_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign run_d      = 1'b1;
  assign rd_vld_d   = rom_en;
  assign rd_owner_d = owner_q;
  assign busy       = (state_q == BURST);
  assign rom_addr   = cur_addr_q;

  always_comb begin
    bus.rvalid = rd_vld_q ? idx2oh(rd_owner_q) : '0;
    bus.done   = (rd_vld_q && rd_last_q) ? idx2oh(rd_owner_q) : '0;
    bus.rdata  = rd_vld_q ? rom_dout : rdata_q;
    rdata_d    = bus.rdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      run_q       <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_owner_q  <= '0;
      rdata_q     <= '0;
`ifndef ROM_RD_ARB_FIXED_PRIO_EN
      last_winner_q <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      run_q       <= run_d;
      rd_vld_q    <= rd_vld_d;
      rd_last_q   <= rd_last_d;
      rd_owner_q  <= rd_owner_d;
      rdata_q     <= rdata_d;
`ifndef ROM_RD_ARB_FIXED_PRIO_EN
      last_winner_q <= last_winner_d;
`endif
    end
  end

endmodule

// File: tb/tb_rom_rd_arbiter.sv
// Bench for rom_rd_arbiter: a cycle-scheduled transaction model checks every output each cycle,
// with a vector table and directed sequences for arbitration, wrap, back-to-back and reset abort.
module tb_rom_rd_arbiter;
  import rom_arb_pkg::*;

  localparam int DW    = 16;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          busy;
  logic          rom_en;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_dout;

  rom_rd_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  rom_rd_arbiter #(.DATA_WIDTH(DW), .ROM_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .busy     (busy),
    .rom_en   (rom_en),
    .rom_addr (rom_addr),
    .rom_dout (rom_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    return {a ^ 8'hA5, ~a};
  endfunction

  always @(posedge clk) if (rom_en) rom_dout <= rom_fn(rom_addr);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each grant schedules its whole burst onto future cycle numbers.
  int            cyc = 0;
  int            free_at = 0;
  logic          lw = 1'b1;
  logic [DW-1:0] last_dat = '0;
  logic [AW-1:0] m_addr[int];
  logic [1:0]    m_rv[int];
  logic [DW-1:0] m_dat[int];
  logic [1:0]    m_done[int];

  always @(negedge clk) begin : model
    logic [1:0]    e_ack, e_rv, e_done;
    logic          e_en;
    logic [DW-1:0] e_dat;
    logic [AW-1:0] a, ak;
    int            w, n;
    cyc++;
    if (!reset_n) begin
      chk("rst_ack", 32'(bus.ack), 32'(0));
      chk("rst_rvalid", 32'(bus.rvalid), 32'(0));
      chk("rst_done", 32'(bus.done), 32'(0));
      chk("rst_rom_en", 32'(rom_en), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_rdata", 32'(bus.rdata), 32'(0));
      chk("rst_rom_addr", 32'(rom_addr), 32'(0));
      m_addr.delete(); m_rv.delete(); m_dat.delete(); m_done.delete();
      free_at  = cyc + 2;
      lw       = 1'b1;
      last_dat = '0;
    end else begin
      e_ack = '0;
      if (cyc >= free_at && bus.req != 2'b00) begin
        if (bus.req == 2'b11) begin
`ifdef ROM_RD_ARB_FIXED_PRIO_EN
          w = 0;
`else
          w = lw ? 0 : 1;
`endif
        end else begin
          w = bus.req[1] ? 1 : 0;
        end
        lw    = (w == 1);
        e_ack = 2'(1 << w);
        a     = (w == 1) ? bus.start_addr1 : bus.start_addr0;
        n     = int'((w == 1) ? bus.len1 : bus.len0);
        if (n == 0) n = DEPTH;
        for (int k = 0; k < n; k++) begin
          ak                 = AW'((int'(a) + k) % DEPTH);
          m_addr[cyc+1+k]    = ak;
          m_rv[cyc+2+k]      = 2'(1 << w);
          m_dat[cyc+2+k]     = rom_fn(ak);
          if (k == n - 1) m_done[cyc+2+k] = 2'(1 << w);
        end
        free_at = cyc + n + 1;
      end
      e_en   = m_addr.exists(cyc);
      e_rv   = m_rv.exists(cyc) ? m_rv[cyc] : 2'b00;
      e_done = m_done.exists(cyc) ? m_done[cyc] : 2'b00;
      e_dat  = (e_rv != 2'b00) ? m_dat[cyc] : last_dat;
      chk("ack", 32'(bus.ack), 32'(e_ack));
      chk("rom_en", 32'(rom_en), 32'(e_en));
      chk("busy", 32'(busy), 32'(e_en));
      if (e_en) chk("rom_addr", 32'(rom_addr), 32'(m_addr[cyc]));
      chk("rvalid", 32'(bus.rvalid), 32'(e_rv));
      chk("done", 32'(bus.done), 32'(e_done));
      chk("rdata", 32'(bus.rdata), 32'(e_dat));
      last_dat = e_dat;
      m_addr.delete(cyc); m_rv.delete(cyc); m_dat.delete(cyc); m_done.delete(cyc);
    end
  end

  typedef struct {
    logic [1:0]    req;
    logic [AW-1:0] a0;
    logic [AW:0]   l0;
    logic [AW-1:0] a1;
    logic [AW:0]   l1;
    logic [1:0]    exp_ack;
    int            exp_n;
    logic [AW-1:0] exp_first;
  } vec_t;

  task automatic send(input logic [1:0] r, input logic [AW-1:0] a0, input logic [AW:0] l0,
                      input logic [AW-1:0] a1, input logic [AW:0] l1, output logic [1:0] ackv);
    @(posedge clk); #1;
    bus.req = r; bus.start_addr0 = a0; bus.len0 = l0; bus.start_addr1 = a1; bus.len1 = l1;
    @(negedge clk);
    ackv = bus.ack;
    @(posedge clk); #1;
    bus.req = 2'b00;
  endtask

  task automatic observe(output int nw, output logic [AW-1:0] first, output logic [1:0] dn);
    bit got;
    nw = 0; first = '0; dn = '0; got = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (rom_en && !got) begin first = rom_addr; got = 1; end
      if (bus.rvalid != 2'b00) nw++;
      if (bus.done != 2'b00) begin dn = bus.done; break; end
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (!busy && bus.rvalid == 2'b00) break;
    end
    chk("idle_reached", 32'(busy), 32'(0));
  endtask

  function automatic logic [AW:0] rand_len();
    int r;
    r = $urandom_range(0, 39);
    return (r == 0) ? '0 : (AW+1)'((r % 8) + 1);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          tbl[6];
    logic [1:0]    ackv, dn;
    logic [1:0]    acks[4];
    logic [1:0]    cont_exp[4];
    logic [AW-1:0] first;
    int            nw, na, last_en, t_ack1;

    tbl[0] = '{2'b01, 8'h10, 9'd4, 8'h00, 9'd1, 2'b01, 4,   8'h10};
    tbl[1] = '{2'b10, 8'h00, 9'd1, 8'hFE, 9'd3, 2'b10, 3,   8'hFE};
    tbl[2] = '{2'b11, 8'h20, 9'd2, 8'h30, 9'd5, 2'b01, 2,   8'h20};
`ifdef ROM_RD_ARB_FIXED_PRIO_EN
    tbl[3] = '{2'b11, 8'h20, 9'd2, 8'h30, 9'd5, 2'b01, 2,   8'h20};
    cont_exp = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
    tbl[3] = '{2'b11, 8'h20, 9'd2, 8'h30, 9'd5, 2'b10, 5,   8'h30};
    cont_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
    tbl[4] = '{2'b10, 8'h00, 9'd1, 8'h05, 9'd0, 2'b10, 256, 8'h05};
    tbl[5] = '{2'b01, 8'hFF, 9'd1, 8'h00, 9'd2, 2'b01, 1,   8'hFF};

    // Contention held through reset release
    bus.req = 2'b11; bus.start_addr0 = 8'h40; bus.len0 = 9'd2;
    bus.start_addr1 = 8'h80; bus.len1 = 9'd2;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    na = 0;
    acks = '{2'b00, 2'b00, 2'b00, 2'b00};
    for (int i = 0; i < 40 && na < 4; i++) begin
      @(negedge clk);
      if (bus.ack != 2'b00) begin acks[na] = bus.ack; na++; end
    end
    @(posedge clk); #1 bus.req = 2'b00;
    for (int i = 0; i < 4; i++) chk($sformatf("cont_ack%0d", i), 32'(acks[i]), 32'(cont_exp[i]));

    for (int v = 0; v < 6; v++) begin
      wait_idle();
      send(tbl[v].req, tbl[v].a0, tbl[v].l0, tbl[v].a1, tbl[v].l1, ackv);
      chk($sformatf("tbl%0d_ack", v), 32'(ackv), 32'(tbl[v].exp_ack));
      observe(nw, first, dn);
      chk($sformatf("tbl%0d_words", v), 32'(nw), 32'(tbl[v].exp_n));
      chk($sformatf("tbl%0d_first", v), 32'(first), 32'(tbl[v].exp_first));
      chk($sformatf("tbl%0d_done", v), 32'(dn), 32'(tbl[v].exp_ack));
    end

    // Back-to-back: req1 raised right after ack0
    wait_idle();
    @(posedge clk); #1;
    bus.req = 2'b01; bus.start_addr0 = 8'h50; bus.len0 = 9'd3;
    bus.start_addr1 = 8'h60; bus.len1 = 9'd2;
    @(negedge clk);
    chk("b2b_ack0", 32'(bus.ack), 32'(2'b01));
    @(posedge clk); #1 bus.req = 2'b10;
    last_en = -1; t_ack1 = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rom_en) last_en = i;
      if (bus.ack[1]) begin t_ack1 = i; break; end
    end
    @(posedge clk); #1 bus.req = 2'b00;
    chk("b2b_ack1_gap", 32'(t_ack1), 32'(last_en + 1));
    chk("b2b_ack1_cycle", 32'(t_ack1), 32'(3));

    // Reset after 2 of 8 words
    wait_idle();
    send(2'b01, 8'h08, 9'd8, 8'h00, 9'd1, ackv);
    chk("mid_ack", 32'(ackv), 32'(2'b01));
    nw = 0;
    for (int i = 0; i < 10 && nw < 2; i++) begin
      @(negedge clk);
      if (bus.rvalid != 2'b00) nw++;
    end
    @(posedge clk); #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_rvalid", 32'(bus.rvalid), 32'(0));
    chk("mid_rst_rom_en", 32'(rom_en), 32'(0));
    chk("mid_rst_busy", 32'(busy), 32'(0));
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    send(2'b01, 8'h00, 9'd4, 8'h00, 9'd1, ackv);
    chk("post_rst_ack", 32'(ackv), 32'(2'b01));
    observe(nw, first, dn);
    chk("post_rst_words", 32'(nw), 32'(4));
    chk("post_rst_first", 32'(first), 32'(0));
    chk("post_rst_done", 32'(dn), 32'(2'b01));

    // Random traffic, checked cycle by cycle by the model
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      bus.req[0]      = ($urandom_range(0, 3) != 0);
      bus.req[1]      = ($urandom_range(0, 3) != 0);
      bus.start_addr0 = AW'($urandom_range(0, DEPTH - 1));
      bus.start_addr1 = AW'($urandom_range(0, DEPTH - 1));
      bus.len0        = rand_len();
      bus.len1        = rand_len();
    end
    @(posedge clk); #1 bus.req = 2'b00;
    wait_idle();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rom_rd_arbiter.md
# rom_rd_arbiter

Read arbiter and burst sequencer for the single-port data ROM (DATA_WIDTH × ROM_DEPTH, synchronous read, 1-cycle latency). It shares the ROM's single read port between two requesters and accepts one burst at a time. Each accepted burst is a start address plus a length, which the block converts into consecutive ROM reads. Returned words are routed back to the owning requester with a valid strobe and an end-of-burst pulse.

## Interface
**Parameters**
- DATA_WIDTH, 16, ROM word width
- ROM_DEPTH, 256, ROM words
- ADDR_WIDTH, $clog2(ROM_DEPTH), ROM address width

**Ports** (clock and reset first)
- clk  in  1  clock; all logic on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- req  in  2  burst request per requester; level, held until ack
- start_addr0 / start_addr1  in  ADDR_WIDTH  first word address of the burst
- len0 / len1  in  ADDR_WIDTH+1  burst length in words; 0 means ROM_DEPTH
- ack  out  2  one-cycle pulse when the burst is accepted
- rvalid  out  2  read data valid, routed to the owning requester
- rdata  out  DATA_WIDTH  read data, shared by both requesters, qualified by rvalid
- done  out  2  pulse coincident with the last rvalid of a burst
- busy  out  1  FSM not IDLE
- rom_en  out  1  ROM read enable
- rom_addr  out  ADDR_WIDTH  ROM read address
- rom_dout  in  DATA_WIDTH  ROM data, valid the cycle after rom_en

## Operation
- **States:** IDLE, BURST.
- **IDLE:**
  - If any req bit is high, select a winner.
  - Pulse ack[winner].
  - Latch start_addr/len of the winner into cur_addr and remaining. len=0 loads ROM_DEPTH.
  - Record owner and go to BURST.
  - If no req, stay in IDLE.
- **BURST:**
  - Every cycle: rom_en=1, rom_addr=cur_addr.
  - cur_addr increments modulo ROM_DEPTH (wraps 255→0 at default depth).
  - remaining decrements.
  - The cycle that issues the read with remaining==1 marks it last and returns to IDLE.
- **Return path:** rom_en, owner and last are delayed one cycle.
  - Next cycle: rvalid[owner_d]=1, rdata=rom_dout.
  - done[owner_d]=last_d.
- **Arbitration:** round-robin.
  - last_winner is updated on each ack.
  - When both requesters are pending, the one not granted last wins.
  - last_winner resets to 1, so requester 0 wins the first tie.
- **Request sampling:** req is not sampled during BURST. A req that drops before ack is simply never served; this is legal.
- **Request/ack overlap:** a requester may reassert req in the cycle after its ack. It then competes in the next IDLE cycle.
- **rdata when idle:** rdata holds its last value when rvalid=0.
- **Reset values:**
  - ack, rvalid, done, rom_en, busy = 0
  - rdata = 0, rom_addr = 0
  - state = IDLE, last_winner = 1
- **Reset mid-burst:** all outputs clear asynchronously. The in-flight read is discarded, and no done pulse is ever produced for the aborted burst.

## Timing
- ack in cycle T. First rom_en in T+1. First rvalid in T+2.
- A burst of N words produces rvalid in T+2 … T+N+1, with done in T+N+1.
- Exactly one IDLE cycle separates bursts, so ROM port utilisation is N/(N+1).
- The last rvalid of burst k may coincide with the ack of burst k+1.
- Throughput: one word per cycle within a burst. No back-pressure; requesters must accept every rvalid.

## Configuration
- **ROM_RD_ARB_FIXED_PRIO_EN defined:** fixed priority; requester 0 always wins when both requesters are pending. last_winner is not implemented.
- **Not defined (default):** round-robin as described under Operation.

## Structure
- **Package rom_arb_pkg:**
  - state enum {IDLE, BURST}
  - NUM_REQ=2
  - requester index type
- **Sub-module rom_rr_arb:**
  - 2-way round-robin/fixed-priority arbiter.
  - Inputs: req, last_winner. Outputs: one-hot grant and index.
  - Contains the macro-dependent logic.

## Test plan
- **Single burst:** req0 with start_addr0=0x10, len0=4 -> ack0 at T; rom_addr 0x10..0x13 in T+1..T+4; rvalid0 in T+2..T+5 with ROM data; done0 at T+5.
- **Contention:** req=2'b11 held from reset, len=2 each -> grants alternate 0,1,0,1. With ROM_RD_ARB_FIXED_PRIO_EN -> grants 0,0,0…
- **Wrap and len=0:** start_addr1=0xFE, len1=3 -> addresses 0xFE, 0xFF, 0x00. len1=0 -> 256 rvalid1 pulses, done1 on the 256th.
- **Back-to-back:** req1 pending during a req0 burst -> ack1 in the cycle after the last rom_en of burst 0; no rvalid overlap and no cross-routing.
- **Reset mid-burst:** assert reset_n=0 after 2 of 8 words -> rvalid, rom_en and busy are 0 immediately. After release, a new burst from 0x00 returns correct data with no stale done.
